// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: pipeline payloads, stage control,
// access widths and the bus FSM state encoding.
package pack;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memoryWidth_;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    DRAIN
  } memoryState_;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;

  typedef struct packed {
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
    logic [4:0]  destinationRegister;
    logic [31:0] result;
    logic [31:0] storeData;
    logic [1:0]  writebackType;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    memoryWidth_ memoryWidth;
    logic        memorySigned;
    logic        valid;
    logic        illegal;
  } executeMemoryPayload_;

  typedef struct packed {
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
    logic [4:0]  destinationRegister;
    logic [31:0] result;
    logic [31:0] loadData;
    logic [1:0]  writebackType;
    logic        valid;
    logic        illegal;
    logic        misaligned;
  } memoryWritebackPayload_;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus: one outstanding request, response is a
// single-cycle pulse per accepted request.
interface memory_stage_if;
  logic        dmemRequestValid;
  logic        dmemRequestReady;
  logic        dmemRequestWrite;
  logic [31:0] dmemAddress;
  logic [31:0] dmemWriteData;
  logic [3:0]  dmemByteEnable;
  logic        dmemResponseValid;
  logic [31:0] dmemReadData;

  modport master (
    output dmemRequestValid, dmemRequestWrite, dmemAddress, dmemWriteData, dmemByteEnable,
    input  dmemRequestReady, dmemResponseValid, dmemReadData
  );

  modport slave (
    input  dmemRequestValid, dmemRequestWrite, dmemAddress, dmemWriteData, dmemByteEnable,
    output dmemRequestReady, dmemResponseValid, dmemReadData
  );
endinterface

// File: rtl/memory_stage_align.sv
// Combinational lane steering: store replication and byte enables, load
// extraction with sign/zero extension, and the width-based alignment check.
module load_store_align
  import pack::*;
(
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  memoryWidth_ width,
  input  logic        isSigned,
  input  logic [31:0] readData,
  output logic [31:0] writeData,
  output logic [3:0]  byteEnable,
  output logic [31:0] loadData,
  output logic        misaligned
);
  logic [1:0]  offset;
  logic [31:0] shifted;

  assign offset  = address[1:0];
  assign shifted = readData >> {offset, 3'b000};

  always_comb begin
    writeData  = storeData;
    byteEnable = 4'b1111;
    loadData   = shifted;
    misaligned = 1'b0;
    case (width)
      MEM_BYTE: begin
        writeData  = {4{storeData[7:0]}};
        byteEnable = 4'b0001 << offset;
        loadData   = {{24{isSigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        writeData  = {2{storeData[15:0]}};
        byteEnable = 4'b0011 << offset;
        loadData   = {{16{isSigned & shifted[15]}}, shifted[15:0]};
        misaligned = offset[0];
      end
      default: misaligned = (offset != 2'b00);
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-memory access at a time, stalls the
// pipe while it is in flight, and registers the aligned result for writeback.
module memory_stage
  import pack::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  control                 memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memoryStallRequest,
  memory_stage_if.master         dmem
);
  memoryState_            state, nextState;
  memoryWritebackPayload_ nextPayload;
  logic [31:0] loadBuffer, alignedLoad, alignedWrite, freshLoad;
  logic [3:0]  alignedEnable;
  logic        widthMisaligned, memoryOperation, misaligned, accessNeeded;
  logic        stall, flush, response, loadOutput, useBuffer, captureBuffer;

  load_store_align align (
    .address   (executeMemoryPayload.result),
    .storeData (executeMemoryPayload.storeData),
    .width     (executeMemoryPayload.memoryWidth),
    .isSigned  (executeMemoryPayload.memorySigned),
    .readData  (dmem.dmemReadData),
    .writeData (alignedWrite),
    .byteEnable(alignedEnable),
    .loadData  (alignedLoad),
    .misaligned(widthMisaligned)
  );

  assign stall           = memoryWritebackControl.stall;
  assign flush           = memoryWritebackControl.flush;
  assign response        = dmem.dmemResponseValid;
  assign memoryOperation = executeMemoryPayload.memoryReadEnable | executeMemoryPayload.memoryWriteEnable;
  assign misaligned      = memoryOperation & widthMisaligned;
  assign accessNeeded    = executeMemoryPayload.valid & ~executeMemoryPayload.illegal
                         & memoryOperation & ~misaligned;
  assign freshLoad       = (accessNeeded & executeMemoryPayload.memoryReadEnable) ? alignedLoad : '0;

  // Request fields are held at zero whenever no request is being presented.
  assign dmem.dmemRequestWrite = dmem.dmemRequestValid & executeMemoryPayload.memoryWriteEnable;
  assign dmem.dmemAddress      = dmem.dmemRequestValid ? {executeMemoryPayload.result[31:2], 2'b00} : '0;
  assign dmem.dmemWriteData    = dmem.dmemRequestValid ? alignedWrite : '0;
  assign dmem.dmemByteEnable   = dmem.dmemRequestWrite ? alignedEnable : 4'b0000;

  always_comb begin
    nextState             = state;
    dmem.dmemRequestValid = 1'b0;
    memoryStallRequest    = 1'b0;
    loadOutput            = 1'b0;
    useBuffer             = 1'b0;
    captureBuffer         = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          dmem.dmemRequestValid = accessNeeded;
          memoryStallRequest    = accessNeeded;
          loadOutput            = ~accessNeeded & ~stall;
          // An access accepted in the same cycle as a flush still owes a response.
          if (accessNeeded && dmem.dmemRequestReady) nextState = flush ? DRAIN : WAIT;
        end
        WAIT: begin
          memoryStallRequest = ~response;
          if (response) begin
            captureBuffer = 1'b1;
            loadOutput    = ~stall;
            nextState     = (stall && !flush) ? DONE : IDLE;
          end else if (flush) begin
            nextState = DRAIN;
          end
        end
        DONE: begin
          useBuffer  = 1'b1;
          loadOutput = ~stall;
          if (!stall || flush) nextState = IDLE;
        end
        DRAIN: begin
          memoryStallRequest = 1'b1;
          if (response) nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    nextPayload                     = '0;
    nextPayload.programCounter      = executeMemoryPayload.programCounter;
    nextPayload.programCounterPlus4 = executeMemoryPayload.programCounterPlus4;
    nextPayload.destinationRegister = executeMemoryPayload.destinationRegister;
    nextPayload.result              = executeMemoryPayload.result;
    nextPayload.loadData            = useBuffer ? loadBuffer : freshLoad;
    nextPayload.writebackType       = executeMemoryPayload.writebackType;
    nextPayload.valid               = executeMemoryPayload.valid;
    nextPayload.illegal             = executeMemoryPayload.illegal;
    nextPayload.misaligned          = misaligned;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= IDLE;
      loadBuffer             <= '0;
      memoryWritebackPayload <= '0;
    end else begin
      state <= nextState;
      if (captureBuffer) loadBuffer <= freshLoad;
      if (flush)           memoryWritebackPayload.valid <= 1'b0;
      else if (loadOutput) memoryWritebackPayload       <= nextPayload;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Randomised scoreboard bench for memory_stage with a behavioural memory responder.
module tb_memory_stage;
  import pack::*;

  logic                   clock = 1'b0;
  logic                   reset;
  executeMemoryPayload_   executeMemoryPayload;
  control                 memoryWritebackControl;
  memoryWritebackPayload_ memoryWritebackPayload;
  logic                   memoryStallRequest;
  logic                   holdStall, flushReq;
  memory_stage_if         dmem ();

  int errors = 0;
  int checks = 0;

  memoryWritebackPayload_ expq[$];
  memoryWritebackPayload_ popped;
  logic [31:0] lastPc, pcNext;
  logic [31:0] curWord, respWord;
  int          curReadyLow, curLat, respLat, respLeft, lowLeft;
  bit          newTxn, hsLast;

  memory_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .executeMemoryPayload  (executeMemoryPayload),
    .memoryWritebackControl(memoryWritebackControl),
    .memoryWritebackPayload(memoryWritebackPayload),
    .memoryStallRequest    (memoryStallRequest),
    .dmem                  (dmem)
  );

  always #5 clock = ~clock;

  // Hazard unit model: the stage's own stall request plus an external hold.
  assign memoryWritebackControl = {memoryStallRequest | holdStall, flushReq};

  task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int widthBytes(memoryWidth_ w);
    case (w)
      MEM_BYTE: return 1;
      MEM_HALF: return 2;
      default:  return 4;
    endcase
  endfunction

  function automatic bit isMisaligned(executeMemoryPayload_ p);
    int a = int'(p.result[1:0]);
    return (p.memoryReadEnable || p.memoryWriteEnable) && (a % widthBytes(p.memoryWidth) != 0);
  endfunction

  function automatic bit needsAccess(executeMemoryPayload_ p);
    return p.valid && !p.illegal && (p.memoryReadEnable || p.memoryWriteEnable) && !isMisaligned(p);
  endfunction

  function automatic memoryWritebackPayload_ model(executeMemoryPayload_ p, logic [31:0] word);
    memoryWritebackPayload_ e;
    int nb = widthBytes(p.memoryWidth);
    logic [31:0] mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    logic [31:0] value = (word >> (8 * int'(p.result[1:0]))) & mask;
    if (p.memorySigned && value[8 * nb - 1]) value = value | ~mask;
    e = '0;
    e.programCounter      = p.programCounter;
    e.programCounterPlus4 = p.programCounterPlus4;
    e.destinationRegister = p.destinationRegister;
    e.result              = p.result;
    e.writebackType       = p.writebackType;
    e.valid               = p.valid;
    e.illegal             = p.illegal;
    e.misaligned          = isMisaligned(p);
    e.loadData            = (needsAccess(p) && p.memoryReadEnable) ? value : 32'h0;
    return e;
  endfunction

  function automatic logic [31:0] expWriteData(executeMemoryPayload_ p);
    logic [31:0] w;
    int nb = widthBytes(p.memoryWidth);
    for (int i = 0; i < 4; i++) w[8 * i +: 8] = p.storeData[8 * (i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] expEnable(executeMemoryPayload_ p);
    int nb = widthBytes(p.memoryWidth);
    if (!p.memoryWriteEnable) return 4'b0000;
    return 4'(((1 << nb) - 1) << int'(p.result[1:0]));
  endfunction

  function automatic executeMemoryPayload_ mk(logic rd, logic wr, memoryWidth_ w, logic sg,
                                              logic [31:0] addr, logic [31:0] sd);
    executeMemoryPayload_ p;
    p = '0;
    p.programCounter      = pcNext;
    p.programCounterPlus4 = pcNext + 32'd4;
    p.destinationRegister = 5'($urandom);
    p.writebackType       = 2'($urandom);
    p.result              = addr;
    p.storeData           = sd;
    p.memoryReadEnable    = rd;
    p.memoryWriteEnable   = wr;
    p.memoryWidth         = w;
    p.memorySigned        = sg;
    p.valid               = 1'b1;
    pcNext                = pcNext + 32'd4;
    return p;
  endfunction

  // Presents one instruction (called just after a rising edge) and holds it until consumed.
  task automatic run(executeMemoryPayload_ p, int rlow, int lat, logic [31:0] word, int hold);
    int cyc = 0;
    int stalls = 0;
    bit reqSeen = 0;
    bit done = 0;
    bit access = needsAccess(p);
    executeMemoryPayload = p;
    curReadyLow = rlow; curLat = lat; curWord = word; newTxn = 1;
    while (!done) begin
      holdStall = (cyc < hold);
      @(negedge clock);
      if (memoryStallRequest) stalls++;
      if (dmem.dmemRequestValid && !reqSeen) begin
        reqSeen = 1;
        check("request_fields", 160'({dmem.dmemRequestWrite, dmem.dmemAddress, dmem.dmemByteEnable}),
              160'({p.memoryWriteEnable, p.result[31:2], 2'b00, expEnable(p)}));
        if (p.memoryWriteEnable) check("store_data", 160'(dmem.dmemWriteData), 160'(expWriteData(p)));
      end
      if (!memoryWritebackControl.stall) begin
        done = 1;
        if (p.valid) expq.push_back(model(p, word));
      end
      cyc++;
      if (cyc > 60) begin
        errors++; checks++;
        $display("FAIL txn_timeout: pc %0h still stalled after %0d cycles, required completion", p.programCounter, cyc);
        done = 1;
      end
      @(posedge clock); #1;
    end
    holdStall = 0;
    check($sformatf("stall_cycles pc=%0h", p.programCounter), 160'(stalls), 160'(access ? rlow + lat : 0));
    check("request_issued", 160'(reqSeen), 160'(access));
  endtask

  // Flushes a load during WAIT and watches the drain period while a new load waits upstream.
  task automatic flushTest(executeMemoryPayload_ p, executeMemoryPayload_ p2);
    bit seenResp = 0;
    executeMemoryPayload = p;
    curReadyLow = 0; curLat = 4; curWord = $urandom; newTxn = 1;
    @(negedge clock);
    check("flush_request_issued", 160'(dmem.dmemRequestValid), 160'(1));
    @(posedge clock); #1;
    flushReq = 1;
    @(negedge clock);
    check("flush_wait_stall", 160'(memoryStallRequest), 160'(1));
    @(posedge clock); #1;
    flushReq = 0;
    executeMemoryPayload = p2;
    newTxn = 1;
    for (int i = 0; i < 10 && !seenResp; i++) begin
      @(negedge clock);
      check("drain_output_valid", 160'(memoryWritebackPayload.valid), 160'(0));
      check("drain_no_request", 160'(dmem.dmemRequestValid), 160'(0));
      check("drain_stall", 160'(memoryStallRequest), 160'(1));
      seenResp = dmem.dmemResponseValid;
      @(posedge clock); #1;
    end
    if (!seenResp) begin
      errors++; checks++;
      $display("FAIL drain_response: no response within bound, required one");
    end
  endtask

  // Memory responder: per-transaction ready-low cycles and response latency.
  initial begin
    dmem.dmemRequestReady = 0; dmem.dmemResponseValid = 0; dmem.dmemReadData = 0;
    respLeft = 0; lowLeft = 0; hsLast = 0; respLat = 1; respWord = 0;
    forever begin
      @(posedge clock); #2;
      dmem.dmemResponseValid = 0;
      if (hsLast) respLeft = respLat;
      if (respLeft > 0) begin
        respLeft--;
        if (respLeft == 0) begin
          dmem.dmemResponseValid = 1;
          dmem.dmemReadData = respWord;
        end
      end
      if (newTxn) begin
        lowLeft = curReadyLow;
        newTxn = 0;
      end
      hsLast = 0;
      dmem.dmemRequestReady = 0;
      if (dmem.dmemRequestValid) begin
        if (lowLeft > 0) lowLeft--;
        else begin
          dmem.dmemRequestReady = 1;
          hsLast = 1;
          respWord = curWord;
          respLat = curLat;
        end
      end
    end
  end

  // Monitor: each new valid writeback result is matched against the queue head.
  initial begin
    lastPc = '0;
    forever begin
      @(negedge clock);
      if (!reset && memoryWritebackPayload.valid && memoryWritebackPayload.programCounter != lastPc) begin
        lastPc = memoryWritebackPayload.programCounter;
        if (expq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_output: got pc %0h, required no output", lastPc);
        end else begin
          popped = expq.pop_front();
          check($sformatf("writeback pc=%0h", popped.programCounter),
                160'(memoryWritebackPayload), 160'(popped));
        end
      end
    end
  end

  initial begin
    executeMemoryPayload_ p, p2;
    int kind;
    reset = 1; holdStall = 0; flushReq = 0; newTxn = 0;
    curReadyLow = 0; curLat = 1; curWord = 0;
    pcNext = 32'h100;
    executeMemoryPayload = mk(1, 0, MEM_WORD, 0, 32'h1000, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_payload", 160'(memoryWritebackPayload), 160'(0));
    check("reset_request", 160'(dmem.dmemRequestValid), 160'(0));
    check("reset_stall", 160'(memoryStallRequest), 160'(0));
    @(posedge clock); #1;
    reset = 0;

    run(mk(1, 0, MEM_BYTE, 1, 32'h1003, 0), 0, 1, 32'h80AABBCC, 0);
    run(mk(1, 0, MEM_BYTE, 0, 32'h1003, 0), 0, 1, 32'h80AABBCC, 0);
    run(mk(0, 1, MEM_HALF, 0, 32'h2002, 32'h1234ABCD), 0, 1, 32'h0, 0);
    run(mk(1, 0, MEM_WORD, 0, 32'h3001, 0), 0, 1, 32'h0, 0);
    run(mk(1, 0, MEM_WORD, 0, 32'h3000, 0), 2, 3, 32'hCAFEF00D, 0);
    run(mk(0, 0, MEM_WORD, 0, 32'h5555, 0), 0, 1, 32'h0, 0);
    p  = mk(1, 0, MEM_WORD, 0, 32'h3100, 0);
    p2 = mk(1, 0, MEM_HALF, 1, 32'h3202, 0);
    flushTest(p, p2);
    run(p2, 0, 1, 32'h9876_5432, 0);
    run(mk(1, 0, MEM_WORD, 0, 32'h4000, 0), 0, 1, 32'hDEADBEEF, 5);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      p = mk(kind >= 2 && kind <= 5 || kind == 9, kind >= 6 && kind <= 8,
             memoryWidth_'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom);
      if (kind == 9) begin
        if ($urandom_range(0, 1) == 1) p.illegal = 1;
        else p.valid = 0;
      end
      run(p, $urandom_range(0, 3), $urandom_range(1, 4), $urandom,
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("scoreboard_drained", 160'(expq.size()), 160'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
